rect_dispatch: RTL and testbench

Command sequencer that sits directly upstream of `render_rect`. It buffers rectangle draw commands in a small FIFO, clips each one to the 320x240 screen, and drops degenerate commands. It drives `render_rect`'s enable/done handshake one rectangle at a time and holds the descriptor stable while each draw runs. It also keeps completion, discard and watchdog status for the scene controller.

---
 rtl/rect_dispatch.sv | 176 +++++++++++++++++
 tb/tb_rect_dispatch.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_dispatch.sv
// Rectangle command sequencer: queues draw commands, clips them to 320x240,
// drops degenerate ones and hands them to render_rect one at a time.
module rect_dispatch #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 131072
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [8:0]               cmd_x,
    input  logic [7:0]               cmd_y,
    input  logic [8:0]               cmd_w,
    input  logic [7:0]               cmd_h,
    input  logic [2:0]               cmd_back,
    input  logic                     cmd_border,
    input  logic [2:0]               cmd_border_color,
    output logic                     enable,
    output logic [8:0]               origin_x,
    output logic [7:0]               origin_y,
    output logic [8:0]               width,
    output logic [7:0]               height,
    output logic [2:0]               back_color,
    output logic                     border,
    output logic [2:0]               border_color,
    input  logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              drawn_count,
    output logic [15:0]              discard_count,
    output logic                     timeout_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = $clog2(TIMEOUT) + 1;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [8:0] w;
        logic [7:0] h;
        logic [2:0] back;
        logic       border;
        logic [2:0] border_color;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ARM,
        DRAW,
        RELEASE
    } state_t;

    cmd_t            mem [DEPTH];
    cmd_t            cmd_in;
    cmd_t            head_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    state_t          state_reg;
    state_t          state_next;
    logic [WDW-1:0]  wd_reg;

    logic            push;
    logic            pop;
    logic            degenerate;
    logic            wd_expired;
    logic [8:0]      room_x;
    logic [7:0]      room_y;
    logic [8:0]      clip_w;
    logic [7:0]      clip_h;

    assign cmd_in = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, back: cmd_back,
                      border: cmd_border, border_color: cmd_border_color};

    // A full FIFO refuses writes even while popping, keeping ready free of the pop path.
    assign cmd_ready  = !reset && (count_reg != CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_reg == FETCH);
    assign fifo_count = count_reg;
    assign enable     = (state_reg == ARM) || (state_reg == DRAW);
    assign busy       = (state_reg != IDLE) || (count_reg != '0);
    assign wd_expired = (wd_reg == WDW'(TIMEOUT - 1));

    // The head entry is registered while IDLE, so FETCH evaluates a stable copy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= cmd_in;
        end
        head_reg <= mem[rd_ptr_reg];
    end

    assign degenerate = (head_reg.x >= 9'd320) || (head_reg.y >= 8'd240) ||
                        (head_reg.w == '0) || (head_reg.h == '0);

    // Remaining room is at most 320/240 once the origin is on screen, so truncation is safe.
    assign room_x = 9'(10'd320 - {1'b0, head_reg.x});
    assign room_y = 8'(10'd240 - {2'b0, head_reg.y});
    assign clip_w = (head_reg.w < room_x) ? head_reg.w : room_x;
    assign clip_h = (head_reg.h < room_y) ? head_reg.h : room_y;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (count_reg != '0) state_next = FETCH;
            FETCH:   state_next = degenerate ? IDLE : ARM;
            ARM:     state_next = DRAW;
            DRAW:    if (done || wd_expired) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            origin_x      <= '0;
            origin_y      <= '0;
            width         <= '0;
            height        <= '0;
            back_color    <= '0;
            border        <= 1'b0;
            border_color  <= '0;
            drawn_count   <= '0;
            discard_count <= '0;
            timeout_err   <= 1'b0;
            wd_reg        <= '0;
        end else begin
            if (state_reg == FETCH) begin
                if (degenerate) begin
                    discard_count <= discard_count + 16'd1;
                end else begin
                    origin_x     <= head_reg.x;
                    origin_y     <= head_reg.y;
                    width        <= clip_w;
                    height       <= clip_h;
                    back_color   <= head_reg.back;
                    border       <= head_reg.border;
                    border_color <= head_reg.border_color;
                end
            end
            // done wins over a watchdog expiry landing on the same edge.
            if (state_reg == DRAW) begin
                wd_reg <= wd_reg + WDW'(1);
                if (done) begin
                    drawn_count <= drawn_count + 16'd1;
                end else if (wd_expired) begin
                    timeout_err <= 1'b1;
                end
            end
            if (state_reg == RELEASE) begin
                wd_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rect_dispatch.sv
// Self-checking bench for rect_dispatch: directed vectors, hand-timed corner
// sequences and random traffic checked against a clipping/queue reference model.
module tb_rect_dispatch;

    localparam int TMO    = 16;
    localparam int MAXLEN = TMO + 1;   // ARM cycle plus TMO DRAW cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [8:0] cmd_x = '0;
    logic [7:0] cmd_y = '0;
    logic [8:0] cmd_w = '0;
    logic [7:0] cmd_h = '0;
    logic [2:0] cmd_back = '0;
    logic       cmd_border = 1'b0;
    logic [2:0] cmd_border_color = '0;
    logic       enable;
    logic [8:0] origin_x;
    logic [7:0] origin_y;
    logic [8:0] width;
    logic [7:0] height;
    logic [2:0] back_color;
    logic       border;
    logic [2:0] border_color;
    logic       done = 1'b0;
    logic       busy;
    logic [3:0] fifo_count;
    logic [15:0] drawn_count;
    logic [15:0] discard_count;
    logic       timeout_err;

    rect_dispatch #(.DEPTH(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_back(cmd_back), .cmd_border(cmd_border), .cmd_border_color(cmd_border_color),
        .enable(enable), .origin_x(origin_x), .origin_y(origin_y),
        .width(width), .height(height), .back_color(back_color),
        .border(border), .border_color(border_color), .done(done),
        .busy(busy), .fifo_count(fifo_count), .drawn_count(drawn_count),
        .discard_count(discard_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [8:0] w;
        logic [7:0] h;
        logic [2:0] back;
        logic       border;
        logic [2:0] bc;
    } desc_t;

    typedef struct {
        int x; int y; int w; int h;
        bit pulse; int ew; int eh;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    desc_t exp_q[$];
    int    exp_drawn = 0;
    int    exp_discard = 0;
    int    exp_timeout = 0;
    desc_t last_desc;
    desc_t cur_desc;
    desc_t exp_d;
    int    en_cyc = 0;
    int    pulse_delay = 0;
    int    done_delay = 3;     // -1: never, -2: random per pulse
    int    gap_cnt = 100;
    int    pulses = 0;
    int    exp_len;
    bit    en_prev = 1'b0;
    bit    drew;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Renderer stand-in and pulse monitor: raises done after a chosen number of
    // enable-high cycles and checks every pulse against the reference queue.
    always @(negedge clk) begin
        if (reset) begin
            en_prev = 1'b0;
            en_cyc  = 0;
            done    = 1'b0;
            gap_cnt = 100;
        end else begin
            cur_desc = {origin_x, origin_y, width, height, back_color, border, border_color};
            if (enable) begin
                if (!en_prev) begin
                    pulses++;
                    chk("enable_spacing", 32'(gap_cnt >= 5), 1);
                    gap_cnt = 0;
                    pulse_delay = (done_delay == -2) ? int'($urandom_range(1, 20)) : done_delay;
                    last_desc = cur_desc;
                    $display("pulse %0d: x=%0d y=%0d w=%0d h=%0d back=%0d border=%0d bc=%0d",
                             pulses, origin_x, origin_y, width, height, back_color, border, border_color);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 1, 0);
                    end else begin
                        exp_d = exp_q.pop_front();
                        chk("desc_x", 32'(cur_desc.x), 32'(exp_d.x));
                        chk("desc_y", 32'(cur_desc.y), 32'(exp_d.y));
                        chk("desc_w", 32'(cur_desc.w), 32'(exp_d.w));
                        chk("desc_h", 32'(cur_desc.h), 32'(exp_d.h));
                        chk("desc_attr", 32'({cur_desc.back, cur_desc.border, cur_desc.bc}),
                            32'({exp_d.back, exp_d.border, exp_d.bc}));
                    end
                end else begin
                    chk("desc_stable", 32'(cur_desc == last_desc), 1);
                end
                en_cyc++;
                done = (pulse_delay >= 1) && (en_cyc >= pulse_delay);
            end else begin
                if (en_prev) begin
                    drew = (pulse_delay >= 1) && (pulse_delay <= MAXLEN);
                    exp_len = drew ? ((pulse_delay < 2) ? 2 : pulse_delay) : MAXLEN;
                    chk("pulse_len", 32'(en_cyc), 32'(exp_len));
                    if (drew) exp_drawn++;
                    else exp_timeout = 1;
                end
                en_cyc = 0;
                done   = 1'b0;
            end
            gap_cnt++;
            en_prev = enable;
        end
    end

    function automatic desc_t model_clip(input int x, input int y, input int w, input int h,
                                         input int back, input int bd, input int bc);
        desc_t d;
        d.x = 9'(x);
        d.y = 8'(y);
        d.w = 9'((w < 320 - x) ? w : 320 - x);
        d.h = 8'((h < 240 - y) ? h : 240 - y);
        d.back = 3'(back);
        d.border = 1'(bd);
        d.bc = 3'(bc);
        return d;
    endfunction

    task automatic push(input int x, input int y, input int w, input int h);
        logic rdy;
        bit   ok;
        int   back, bd, bc;
        back = $urandom_range(0, 7);
        bd   = $urandom_range(0, 1);
        bc   = $urandom_range(0, 7);
        cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
        cmd_back = 3'(back); cmd_border = 1'(bd); cmd_border_color = 3'(bc);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("push_accept", 32'(ok), 1);
        if (ok) begin
            if (x >= 320 || y >= 240 || w == 0 || h == 0) exp_discard++;
            else exp_q.push_back(model_clip(x, y, w, h, back, bd, bc));
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_reached", 32'(t < 3000), 1);
        chk("model_drained", 32'(exp_q.size()), 0);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_drawn"}, 32'(drawn_count), 32'(exp_drawn));
        chk({tag, "_discard"}, 32'(discard_count), 32'(exp_discard));
        chk({tag, "_timeout"}, 32'(timeout_err), 32'(exp_timeout));
    endtask

    vec_t vecs[11];

    initial begin
        int p0, d0, x, y, w, h;
        vecs[0]  = '{10, 20, 5, 4, 1, 5, 4};
        vecs[1]  = '{300, 230, 50, 20, 1, 20, 10};
        vecs[2]  = '{319, 239, 1, 1, 1, 1, 1};
        vecs[3]  = '{0, 0, 511, 255, 1, 320, 240};
        vecs[4]  = '{320, 0, 5, 5, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 7, 0, 0, 0};
        vecs[6]  = '{0, 240, 3, 3, 0, 0, 0};
        vecs[7]  = '{511, 255, 1, 1, 0, 0, 0};
        vecs[8]  = '{100, 100, 300, 200, 1, 220, 140};
        vecs[9]  = '{5, 5, 9, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 320, 240, 1, 320, 240};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_enable", 32'(enable), 0);
        chk("rst_fifo_count", 32'(fifo_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_desc", 32'({origin_x, width}), 0);
        check_counts("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

        // Single command, cycle by cycle
        done_delay = 3;
        push(10, 20, 5, 4);
        chk("lat_e0_enable", 32'(enable), 0);
        chk("lat_e0_count", 32'(fifo_count), 1);
        @(negedge clk);
        chk("lat_e1_enable", 32'(enable), 0);
        @(negedge clk);
        chk("lat_e2_enable", 32'(enable), 1);
        chk("lat_e2_count", 32'(fifo_count), 0);
        chk("lat_e2_desc", 32'({origin_x, origin_y, width, height}), 32'({9'd10, 8'd20, 9'd5, 8'd4}));
        @(negedge clk);
        chk("lat_e3_enable", 32'(enable), 1);
        @(negedge clk);
        chk("lat_e4_enable", 32'(enable), 1);
        @(negedge clk);
        chk("lat_release_enable", 32'(enable), 0);
        chk("lat_release_busy", 32'(busy), 1);
        @(negedge clk);
        chk("lat_idle_busy", 32'(busy), 0);
        chk("lat_drawn", 32'(drawn_count), 1);

        // Directed clipping / degenerate table
        for (int i = 0; i < 11; i++) begin
            p0 = pulses;
            d0 = exp_discard;
            done_delay = 2 + (i % 3);
            push(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h);
            wait_idle();
            chk($sformatf("vec%0d_pulse", i), 32'(pulses - p0), 32'(vecs[i].pulse));
            chk($sformatf("vec%0d_discard", i), 32'(discard_count), 32'(d0 + (vecs[i].pulse ? 0 : 1)));
            if (vecs[i].pulse) begin
                chk($sformatf("vec%0d_wh", i), 32'({last_desc.w, last_desc.h}),
                    32'({9'(vecs[i].ew), 8'(vecs[i].eh)}));
                chk($sformatf("vec%0d_xy", i), 32'({last_desc.x, last_desc.y}),
                    32'({9'(vecs[i].x), 8'(vecs[i].y)}));
            end
        end
        check_counts("table");

        // Two degenerates followed by a real command, back to back
        p0 = pulses;
        d0 = exp_discard;
        push(320, 0, 5, 5);
        push(0, 0, 0, 7);
        push(5, 5, 2, 2);
        wait_idle();
        chk("degen_discard", 32'(discard_count), 32'(d0 + 2));
        chk("degen_pulses", 32'(pulses - p0), 1);
        chk("degen_desc", 32'({last_desc.x, last_desc.y, last_desc.w, last_desc.h}),
            32'({9'd5, 8'd5, 9'd2, 8'd2}));

        // Backpressure with the first draw stalled until the watchdog fires
        done_delay = -1;
        p0 = drawn_count;
        for (int i = 0; i < 9; i++) push(10 + i, 20 + i, 30 + i, 40 + i);
        chk("bp_full_count", 32'(fifo_count), 8);
        chk("bp_full_ready", 32'(cmd_ready), 0);
        chk("bp_drawing", 32'(enable), 1);
        push(200, 100, 7, 9);
        chk("bp_accept_after_watchdog", 32'(timeout_err), 1);
        chk("bp_count_after", 32'(fifo_count), 8);
        chk("wd_drawn_unchanged", 32'(drawn_count), 32'(p0));
        done_delay = 2;
        wait_idle();
        check_counts("bp");

        // Reset in the middle of a draw with three entries queued
        done_delay = -1;
        for (int i = 0; i < 4; i++) push(50 + i, 60, 10, 10);
        chk("mid_enable", 32'(enable), 1);
        chk("mid_count", 32'(fifo_count), 3);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_enable", 32'(enable), 0);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        exp_q.delete();
        exp_drawn = 0;
        exp_discard = 0;
        exp_timeout = 0;
        check_counts("mid_rst");
        reset = 1'b0;
        p0 = pulses;
        repeat (30) @(negedge clk);
        chk("post_rst_no_pulse", 32'(pulses - p0), 0);
        chk("post_rst_busy", 32'(busy), 0);
        done_delay = 2;
        push(1, 2, 3, 4);
        wait_idle();
        check_counts("post_rst");

        // Random traffic against the reference model
        done_delay = -2;
        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(320, 511)) : int'($urandom_range(0, 319));
            y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(240, 255)) : int'($urandom_range(0, 239));
            w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 511));
            h = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
            push(x, y, w, h);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        check_counts("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "simulation time limit");
    end

endmodule
